hor_player_mover: RTL and testbench

- Controls one team's horizontally-moving player. The player travels along a fixed row (VER_POS) and is driven by two active-low buttons.
- Position is clamped to the field edges and blocked from overlapping the teammate vertical player, who sits at column BLOCKING_BALL_X.
- A bludger hit freezes the player for a stun period, with a seconds countdown. A clean pulse tells the bludger controller the stun is over.
- Sits in the game controller beside the vertical-player, ball and bludger controllers.

---
 rtl/hor_player_mover_if.sv | 31 +++
 rtl/hor_player_mover.sv | 156 +++++++++++++++
 tb/tb_hor_player_mover.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hor_player_mover_if.sv
// Bundles the control inputs and status outputs of the horizontal player mover.
// The game controller drives through master; the mover itself uses slave.
interface hor_player_mover_if;
  logic       bludged;
  logic       left_button;
  logic       right_button;
  logic [9:0] ver_position;
  logic [9:0] hor_position;
  logic       clean;
  logic [3:0] bludge_time;

  modport master (
    output bludged,
    output left_button,
    output right_button,
    output ver_position,
    input  hor_position,
    input  clean,
    input  bludge_time
  );

  modport slave (
    input  bludged,
    input  left_button,
    input  right_button,
    input  ver_position,
    output hor_position,
    output clean,
    output bludge_time
  );
endinterface

// File: rtl/hor_player_mover.sv
// Horizontal player mover: button-driven stepping, edge clamping and bludger stun.
// Define HOR_PLAYER_BLOCK_EN to stop the player overlapping the teammate vertical player.
module hor_player_mover #(
  parameter int PLAYER_RADIUS      = 16,
  parameter int INITIAL_HOR_POS    = 400,
  parameter int VER_POS            = 370,
  parameter int MOVEMENT_FREQUENCY = 250000,
  parameter int BLOCKING_BALL_X    = 240,
  parameter int LEFT_BOUNDARY      = 36,
  parameter int RIGHT_BOUNDARY     = 764,
  parameter int STUN_SECONDS       = 5,
  parameter int SECOND_CYCLES      = 50000000
) (
  input logic clk,
  input logic rst_n,
  hor_player_mover_if.slave bus
);

  localparam int STEP_W = (MOVEMENT_FREQUENCY > 1) ? $clog2(MOVEMENT_FREQUENCY) : 1;
  localparam int SEC_W  = (SECOND_CYCLES > 1) ? $clog2(SECOND_CYCLES) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MOVEMENT_FREQUENCY - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SECOND_CYCLES - 1);

  localparam logic signed [10:0] LEFT_S  = 11'(LEFT_BOUNDARY);
  localparam logic signed [10:0] RIGHT_S = 11'(RIGHT_BOUNDARY);
  localparam logic [3:0]         STUN_INIT = 4'(STUN_SECONDS);

  typedef enum logic {
    IDLE,
    STUNNED
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        hor_q, hor_d;
  logic              clean_q, clean_d;
  logic [3:0]        btime_q, btime_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              bludged_q;

  logic              tick;
  logic              bludge_rise;
  logic              want_move;
  logic signed [10:0] cand;
  logic              in_bounds;
  logic              blocked;
  logic              move_ok;

  assign tick        = (step_q == STEP_LAST);
  assign bludge_rise = bus.bludged & ~bludged_q;

  // Candidate is formed in 11-bit signed space so pos-1 at zero cannot wrap.
  always_comb begin
    want_move = 1'b0;
    cand      = $signed({1'b0, hor_q});
    if (!bus.left_button && bus.right_button) begin
      want_move = 1'b1;
      cand      = $signed({1'b0, hor_q}) - 11'sd1;
    end else if (bus.left_button && !bus.right_button) begin
      want_move = 1'b1;
      cand      = $signed({1'b0, hor_q}) + 11'sd1;
    end
  end

  assign in_bounds = (cand >= LEFT_S) && (cand <= RIGHT_S);

`ifdef HOR_PLAYER_BLOCK_EN
  localparam logic [10:0]        MIN_GAP  = 11'(2 * PLAYER_RADIUS);
  localparam logic signed [10:0] ROW_S    = 11'(VER_POS);
  localparam logic signed [10:0] BLOCK_XS = 11'(BLOCKING_BALL_X);

  function automatic logic [10:0] abs_diff(input logic signed [10:0] a,
                                           input logic signed [10:0] b);
    logic signed [10:0] d;
    d = a - b;
    return (d < 0) ? 11'(-d) : 11'(d);
  endfunction

  logic in_row;
  assign in_row  = abs_diff($signed({1'b0, bus.ver_position}), ROW_S) < MIN_GAP;
  assign blocked = in_row && (abs_diff(cand, BLOCK_XS) < MIN_GAP);
`else
  logic unused_ver;
  assign unused_ver = ^bus.ver_position;
  assign blocked    = 1'b0;
`endif

  assign move_ok = want_move && in_bounds && !blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hor_q     <= 10'(INITIAL_HOR_POS);
      clean_q   <= 1'b0;
      btime_q   <= 4'd0;
      step_q    <= '0;
      sec_q     <= '0;
      bludged_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hor_q     <= hor_d;
      clean_q   <= clean_d;
      btime_q   <= btime_d;
      step_q    <= step_d;
      sec_q     <= sec_d;
      bludged_q <= bus.bludged;
    end
  end

  // A stun edge outranks a coincident step tick; bludged edges are ignored while stunned.
  always_comb begin
    state_d = state_q;
    hor_d   = hor_q;
    clean_d = 1'b0;
    btime_d = btime_q;
    step_d  = tick ? '0 : step_q + STEP_W'(1);
    sec_d   = sec_q;

    case (state_q)
      IDLE: begin
        sec_d = '0;
        if (bludge_rise) begin
          state_d = STUNNED;
          btime_d = STUN_INIT;
        end else if (tick && move_ok) begin
          hor_d = cand[9:0];
        end
      end

      STUNNED: begin
        if (sec_q == SEC_LAST) begin
          sec_d = '0;
          if (btime_q <= 4'd1) begin
            btime_d = 4'd0;
            clean_d = 1'b1;
            state_d = IDLE;
          end else begin
            btime_d = btime_q - 4'd1;
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.hor_position = hor_q;
  assign bus.clean        = clean_q;
  assign bus.bludge_time  = btime_q;

endmodule

// File: tb/tb_hor_player_mover.sv
// Directed bench for hor_player_mover with a 4-cycle step and 10-cycle second.
// Expected positions near the teammate depend on HOR_PLAYER_BLOCK_EN.
module tb_hor_player_mover;

  logic clk;
  logic rst_n;
  int   total_checks;
  int   bad_checks;

  hor_player_mover_if bus ();

  hor_player_mover #(
    .PLAYER_RADIUS      (16),
    .INITIAL_HOR_POS    (400),
    .VER_POS            (370),
    .MOVEMENT_FREQUENCY (4),
    .BLOCKING_BALL_X    (240),
    .LEFT_BOUNDARY      (36),
    .RIGHT_BOUNDARY     (764),
    .STUN_SECONDS       (5),
    .SECOND_CYCLES      (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef HOR_PLAYER_BLOCK_EN
  localparam int EXP_ROW_STOP  = 272;
  localparam int EXP_ROW_BACK  = 273;
  localparam int EXP_EDGE_STOP = 208;
  localparam int EXP_EDGE_FREE = 209;
`else
  localparam int EXP_ROW_STOP  = 260;
  localparam int EXP_ROW_BACK  = 261;
  localparam int EXP_EDGE_STOP = 211;
  localparam int EXP_EDGE_FREE = 212;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drives inputs at a falling edge, runs the given rising edges, returns on a falling edge.
  task automatic applyStimulus(input logic left, input logic right, input logic hit,
                               input logic [9:0] ver, input int cycles);
    bus.left_button  = left;
    bus.right_button = right;
    bus.bludged      = hit;
    bus.ver_position = ver;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n            = 1'b0;
    bus.left_button  = 1'b1;
    bus.right_button = 1'b1;
    bus.bludged      = 1'b0;
    bus.ver_position = 10'd100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int clean_seen;
    total_checks = 0;
    bad_checks   = 0;
    rst_n        = 1'b0;
    @(negedge clk);

    doReset();
    checkOutput("reset_pos", int'(bus.hor_position), 400);
    checkOutput("reset_clean", int'(bus.clean), 0);
    checkOutput("reset_btime", int'(bus.bludge_time), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 10'd100, 40);
    checkOutput("right_40", int'(bus.hor_position), 410);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd100, 40);
    checkOutput("both_held", int'(bus.hor_position), 410);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd100, 8);
    checkOutput("none_held", int'(bus.hor_position), 410);

    applyStimulus(1'b0, 1'b1, 1'b0, 10'd370, 600);
    checkOutput("row_left_stop", int'(bus.hor_position), EXP_ROW_STOP);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd370, 4);
    checkOutput("row_move_away", int'(bus.hor_position), EXP_ROW_BACK);

    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 1000);
    checkOutput("left_boundary", int'(bus.hor_position), 36);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 100);
    checkOutput("left_boundary_hold", int'(bus.hor_position), 36);

    applyStimulus(1'b1, 1'b0, 1'b0, 10'd339, 700);
    checkOutput("row_edge_right", int'(bus.hor_position), EXP_EDGE_STOP);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd338, 4);
    checkOutput("out_of_row_step", int'(bus.hor_position), EXP_EDGE_FREE);

    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd100, 1480);
    checkOutput("right_boundary", int'(bus.hor_position), 764);

    // Stun edge lands on the 4th rising edge after reset, which is also a step tick.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd100, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd100, 1);
    checkOutput("stun_start", int'(bus.bludge_time), 5);
    checkOutput("stun_beats_tick", int'(bus.hor_position), 400);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 9);
    checkOutput("stun_s5_end", int'(bus.bludge_time), 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 1);
    checkOutput("stun_s4", int'(bus.bludge_time), 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 10);
    checkOutput("stun_s3", int'(bus.bludge_time), 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 10);
    checkOutput("stun_s2", int'(bus.bludge_time), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 10);
    checkOutput("stun_s1", int'(bus.bludge_time), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 9);
    checkOutput("stun_s1_end", int'(bus.bludge_time), 1);
    checkOutput("clean_early", int'(bus.clean), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 1);
    checkOutput("stun_over", int'(bus.bludge_time), 0);
    checkOutput("clean_pulse", int'(bus.clean), 1);
    checkOutput("stun_frozen", int'(bus.hor_position), 400);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100, 1);
    checkOutput("clean_one_cycle", int'(bus.clean), 0);

    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd100, 1);
    checkOutput("held_start", int'(bus.bludge_time), 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd100, 50);
    checkOutput("held_clean", int'(bus.clean), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd100, 20);
    checkOutput("held_no_restun", int'(bus.bludge_time), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd100, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd100, 1);
    checkOutput("new_edge_restun", int'(bus.bludge_time), 5);

    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd100, 20);
    checkOutput("mid_stun_s3", int'(bus.bludge_time), 3);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_btime", int'(bus.bludge_time), 0);
    checkOutput("abort_pos", int'(bus.hor_position), 400);
    checkOutput("abort_clean", int'(bus.clean), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clean_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.clean) clean_seen++;
    end
    checkOutput("abort_no_clean", clean_seen, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
